cofre_ctrl: RTL and testbench
=============================

COFRE_CTRL -- requirements
Module: cofre_ctrl

Interface
REQ-001 SHALL have parameter OPEN_CYCLES, default 20, door-open duration in clk cycles.
REQ-002 SHALL have parameter LOCK_CYCLES, default 50, lockout duration in clk cycles.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 40, maximum idle gap between key presses during entry.
REQ-004 SHALL have parameter MAX_FAIL, default 3, number of consecutive failed codes that triggers lockout.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port x, input, 2, key symbol; 2'b00 means no key.
REQ-008 SHALL have port prog, input, 1, reprogram request, sampled only at the first press made in OPEN.
REQ-009 SHALL have port y, output, 1, door open, registered.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on a wrong 5-symbol code.
REQ-011 SHALL have port alarm, output, 1, high throughout LOCKOUT.
REQ-012 SHALL have port fail_cnt, output, 2, count of consecutive failures.

Function
REQ-013 SHALL register x into x_prev each cycle; a press SHALL be detected when x!=00 and x_prev==00, giving one press per key, however long the key is held.
REQ-014 SHALL implement the states IDLE, ENTRY, OPEN, PROG and LOCKOUT; all outputs SHALL come from registers.
REQ-015 SHALL hold a 5-symbol code register that resets to 01,11,01,01,10.
REQ-016 In IDLE, a press SHALL store symbol 1 and move to ENTRY with digit index 1.
REQ-017 In ENTRY, each press SHALL store the next symbol, and the code SHALL be compared only after the 5th symbol, with no early reject.
REQ-018 On a match, the FSM SHALL move to OPEN at the edge sampling the 5th press, so y=1 from that edge, and fail_cnt SHALL clear.
REQ-019 On a mismatch:
- err SHALL pulse for 1 cycle after that edge.
- fail_cnt SHALL increment.
- The FSM SHALL go to IDLE, or to LOCKOUT if the new fail_cnt==MAX_FAIL.
REQ-020 In ENTRY or PROG, TIMEOUT_CYCLES with no press SHALL discard the symbols and return to IDLE, with no failure counted and the code unchanged.
REQ-021 In ENTRY or PROG, a press on the same cycle the timeout would expire SHALL win and restart the timer.
REQ-022 In OPEN, y SHALL stay 1 for exactly OPEN_CYCLES cycles, and the FSM SHALL then return to IDLE with y=0.
REQ-023 In OPEN, a first press with prog=1 SHALL store new symbol 1 and move to PROG; a press with prog=0 SHALL be ignored.
REQ-024 In OPEN, expiry of the open timer SHALL take precedence over a press on the same cycle, and that press SHALL be ignored.
REQ-025 In PROG, y SHALL remain 1.
REQ-026 In PROG, the 5th press SHALL commit all 5 new symbols to the code register in one cycle and the FSM SHALL go to IDLE with y=0; a partial entry SHALL never alter the code.
REQ-027 In LOCKOUT, alarm=1 and all presses SHALL be ignored for LOCK_CYCLES cycles; the FSM SHALL then go to IDLE with alarm=0 and fail_cnt=0.
REQ-028 fail_cnt SHALL saturate at MAX_FAIL and never wrap.
REQ-029 Every timer SHALL be sized from its parameter so that no wrap-around occurs.

Reset
REQ-030 While rst=0, the state SHALL be IDLE, with y=0, err=0, alarm=0, fail_cnt=0, all timers 0, x_prev=00 and the code at its default.
REQ-031 Reset asserted mid-operation (ENTRY, OPEN, PROG or LOCKOUT) SHALL abort immediately and asynchronously and discard any partial symbols.
REQ-032 After rst rises, a key already held at that moment SHALL count as a press on the first edge.

Verification
REQ-033 Bench SHALL check the default code: presses 01,11,01,01,10, each a 1-cycle key followed by 3 cycles of 00 -> y=1 at the edge after the 5th press, y=1 for 20 cycles, then y=0, fail_cnt=0.
REQ-034 Bench SHALL check a held key: 01 held for 10 cycles, then 11,01,01,10 -> counted as one press and the door opens.
REQ-035 Bench SHALL check lockout: 3 wrong codes -> err pulses 3 times, fail_cnt goes 1,2 then 3 with alarm=1 for 50 cycles; a correct code entered during LOCKOUT leaves y=0; afterwards fail_cnt=0 and the correct code opens.
REQ-036 Bench SHALL check reprogramming: open the door, then with prog=1 press 10,10,01,11,01 -> y=0; the old code is rejected (err=1) and 10,10,01,11,01 opens.
REQ-037 Bench SHALL check entry timeout: 3 presses then 40 idle cycles -> IDLE with fail_cnt unchanged; a full correct code then opens.
REQ-038 Bench SHALL check reset mid-operation: rst=0 during PROG after 3 new symbols -> y=0 immediately and the default code opens.

Source files
------------

// File: rtl/cofre_ctrl.sv
// Keypad safe controller: 5-symbol code entry, timed door opening, code reprogramming
// and lockout after repeated wrong codes. Every output comes straight from a flop.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | door closed, waiting for the first symbol
// S_ENTRY   | collecting symbols 2..5 of an unlock attempt
// S_OPEN    | door open for OPEN_CYCLES, first press may start reprogramming
// S_PROG    | door held open, collecting 5 new code symbols
// S_LOCKOUT | alarm raised, keypad ignored for LOCK_CYCLES
module cofre_ctrl #(
  parameter int OPEN_CYCLES    = 20,
  parameter int LOCK_CYCLES    = 50,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int MAX_FAIL       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x,
  input  logic       prog,
  output logic       y,
  output logic       err,
  output logic       alarm,
  output logic [1:0] fail_cnt
);

  localparam int T_MAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int T_MAX    = (T_MAX_OL > TIMEOUT_CYCLES) ? T_MAX_OL : TIMEOUT_CYCLES;
  localparam int TW       = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_TMO  = TW'(TIMEOUT_CYCLES - 1);

  // symbol k of the code lives in bits [2k+1:2k]; default sequence 01,11,01,01,10
  localparam logic [9:0] CODE_DEFAULT = 10'b10_01_01_11_01;
  localparam logic [1:0] FAIL_LIMIT   = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_x_prev;
  logic [9:0]    r_code, w_code_nxt;
  logic [7:0]    r_buf, w_buf_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_open_used, w_open_used_nxt;
  logic          r_y, w_y_nxt;
  logic          r_err, w_err_nxt;
  logic          r_alarm, w_alarm_nxt;
  logic [1:0]    r_fail, w_fail_nxt;

  logic          w_press;
  logic          w_last;
  logic          w_tmo;
  logic [7:0]    w_shift;
  logic [7:0]    w_first;
  logic [9:0]    w_entry;
  logic [1:0]    w_fail_inc;

  assign w_press    = (x != 2'b00) && (r_x_prev == 2'b00);
  assign w_last     = (r_idx == 3'd4);
  assign w_tmo      = (r_timer == '0);
  // symbols shift in from the top, so after four presses symbol 1 sits at [1:0]
  assign w_shift    = {x, r_buf[7:2]};
  assign w_first    = {x, 6'b0};
  assign w_entry    = {x, r_buf};
  assign w_fail_inc = (r_fail >= FAIL_LIMIT) ? r_fail : r_fail + 2'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_buf_nxt       = r_buf;
    w_idx_nxt       = r_idx;
    w_timer_nxt     = r_timer;
    w_open_used_nxt = r_open_used;
    w_y_nxt         = r_y;
    w_err_nxt       = 1'b0;
    w_alarm_nxt     = r_alarm;
    w_fail_nxt      = r_fail;

    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_buf_nxt   = w_first;
          w_idx_nxt   = 3'd1;
          w_timer_nxt = T_TMO;
          w_state_nxt = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (w_press) begin
          w_timer_nxt = T_TMO;
          if (w_last) begin
            if (w_entry == r_code) begin
              w_state_nxt     = S_OPEN;
              w_y_nxt         = 1'b1;
              w_fail_nxt      = 2'd0;
              w_timer_nxt     = T_OPEN;
              w_open_used_nxt = 1'b0;
            end else begin
              w_err_nxt  = 1'b1;
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == FAIL_LIMIT) begin
                w_state_nxt = S_LOCKOUT;
                w_alarm_nxt = 1'b1;
                w_timer_nxt = T_LOCK;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end else begin
            w_buf_nxt = w_shift;
            w_idx_nxt = r_idx + 3'd1;
          end
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      S_OPEN: begin
        // only the first press while open is looked at; prog decides its fate
        if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_y_nxt     = 1'b0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
          if (w_press && !r_open_used) begin
            w_open_used_nxt = 1'b1;
            if (prog) begin
              w_buf_nxt   = w_first;
              w_idx_nxt   = 3'd1;
              w_timer_nxt = T_TMO;
              w_state_nxt = S_PROG;
            end
          end
        end
      end

      S_PROG: begin
        if (w_press) begin
          w_timer_nxt = T_TMO;
          if (w_last) begin
            w_code_nxt  = w_entry;
            w_state_nxt = S_IDLE;
            w_y_nxt     = 1'b0;
          end else begin
            w_buf_nxt = w_shift;
            w_idx_nxt = r_idx + 3'd1;
          end
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_y_nxt     = 1'b0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_alarm_nxt = 1'b0;
          w_fail_nxt  = 2'd0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_y_nxt     = 1'b0;
        w_alarm_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_x_prev    <= 2'b00;
      r_code      <= CODE_DEFAULT;
      r_buf       <= 8'd0;
      r_idx       <= 3'd0;
      r_timer     <= '0;
      r_open_used <= 1'b0;
      r_y         <= 1'b0;
      r_err       <= 1'b0;
      r_alarm     <= 1'b0;
      r_fail      <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_x_prev    <= x;
      r_code      <= w_code_nxt;
      r_buf       <= w_buf_nxt;
      r_idx       <= w_idx_nxt;
      r_timer     <= w_timer_nxt;
      r_open_used <= w_open_used_nxt;
      r_y         <= w_y_nxt;
      r_err       <= w_err_nxt;
      r_alarm     <= w_alarm_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  assign y        = r_y;
  assign err      = r_err;
  assign alarm    = r_alarm;
  assign fail_cnt = r_fail;

endmodule

// File: tb/tb_cofre_ctrl.sv
// Bench for cofre_ctrl: directed scenarios plus random keypad traffic, all checked
// every cycle against a symbol-queue model of the safe.
module tb_cofre_ctrl;

  localparam int OPEN_C = 20;
  localparam int LOCK_C = 50;
  localparam int TMO_C  = 40;
  localparam int MAXF   = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_PROG  = 3;
  localparam int M_LOCK  = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       prog = 1'b0;
  logic [1:0] x    = 2'b00;
  logic       y, err, alarm;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  cofre_ctrl #(
    .OPEN_CYCLES(OPEN_C),
    .LOCK_CYCLES(LOCK_C),
    .TIMEOUT_CYCLES(TMO_C),
    .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .prog(prog),
    .y(y),
    .err(err),
    .alarm(alarm),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int code_def [5] = '{1, 3, 1, 1, 2};
  int code_new [5] = '{2, 2, 1, 3, 1};
  int code_bad [5] = '{2, 2, 2, 2, 2};

  // model: the safe as a list of typed symbols, a stored code and elapsed-cycle counts
  int m_mode;
  int m_q[$];
  int m_code [5];
  int m_gap;
  int m_age;
  bit m_open_pressed;
  int m_prev_x;
  bit e_y, e_err, e_alarm;
  int e_fail;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    m_code = code_def;
    m_gap = 0;
    m_age = 0;
    m_open_pressed = 1'b0;
    m_prev_x = 0;
    e_y = 1'b0;
    e_err = 1'b0;
    e_alarm = 1'b0;
    e_fail = 0;
  endfunction

  function automatic bit code_matches();
    for (int i = 0; i < 5; i++)
      if (m_q[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input int xi, input bit pi);
    bit press;
    press = (xi != 0) && (m_prev_x == 0);
    m_prev_x = xi;
    e_err = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (press) begin
          m_q.delete();
          m_q.push_back(xi);
          m_gap = 0;
          m_mode = M_ENTRY;
        end
      end
      M_ENTRY, M_PROG: begin
        if (press) begin
          m_q.push_back(xi);
          m_gap = 0;
          if (m_q.size() == 5) begin
            if (m_mode == M_PROG) begin
              for (int i = 0; i < 5; i++) m_code[i] = m_q[i];
              e_y = 1'b0;
              m_mode = M_IDLE;
            end else if (code_matches()) begin
              m_mode = M_OPEN;
              e_y = 1'b1;
              e_fail = 0;
              m_age = 0;
              m_open_pressed = 1'b0;
            end else begin
              e_err = 1'b1;
              if (e_fail < MAXF) e_fail++;
              if (e_fail == MAXF) begin
                m_mode = M_LOCK;
                e_alarm = 1'b1;
                m_age = 0;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
        end else begin
          m_gap++;
          if (m_gap == TMO_C) begin
            m_mode = M_IDLE;
            e_y = 1'b0;
          end
        end
      end
      M_OPEN: begin
        m_age++;
        if (m_age == OPEN_C) begin
          m_mode = M_IDLE;
          e_y = 1'b0;
        end else if (press && !m_open_pressed) begin
          m_open_pressed = 1'b1;
          if (pi) begin
            m_q.delete();
            m_q.push_back(xi);
            m_gap = 0;
            m_mode = M_PROG;
          end
        end
      end
      M_LOCK: begin
        m_age++;
        if (m_age == LOCK_C) begin
          m_mode = M_IDLE;
          e_alarm = 1'b0;
          e_fail = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_step(int'(x), prog);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // observed run lengths, compared against hand-counted literals in the scenarios
  int y_run = 0, last_y_run = 0;
  int alarm_run = 0, last_alarm_run = 0;
  int err_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("y", {31'd0, y}, {31'd0, e_y});
      check("err", {31'd0, err}, {31'd0, e_err});
      check("alarm", {31'd0, alarm}, {31'd0, e_alarm});
      check("fail_cnt", {30'd0, fail_cnt}, 32'(e_fail));
      if (y === 1'b1) y_run++;
      else if (y_run != 0) begin last_y_run = y_run; y_run = 0; end
      if (alarm === 1'b1) alarm_run++;
      else if (alarm_run != 0) begin last_alarm_run = alarm_run; alarm_run = 0; end
      if (err === 1'b1) err_count++;
    end
  end

  task automatic press_key(input int sym, input int hold, input int gap);
    x = 2'(sym);
    repeat (hold) @(negedge clk);
    x = 2'b00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic enter_code(input int c [5]);
    for (int i = 0; i < 5; i++) press_key(c[i], 1, 3);
  endtask

  task automatic idle(input int n);
    x = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  int err_base;
  int cur [5];

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_y", {31'd0, y}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    check("rst_fail", {30'd0, fail_cnt}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);

    // default code, short presses
    enter_code(code_def);
    check("default_open", {31'd0, y}, 32'd1);
    idle(25);
    check("open_len", 32'(last_y_run), 32'd20);
    check("default_closed", {31'd0, y}, 32'd0);
    check("default_fail", {30'd0, fail_cnt}, 32'd0);

    // first key held for 10 cycles counts once
    press_key(1, 10, 3);
    for (int i = 1; i < 5; i++) press_key(code_def[i], 1, 3);
    check("held_open", {31'd0, y}, 32'd1);
    idle(25);

    // entry timeout keeps fail_cnt
    err_base = err_count;
    enter_code(code_bad);
    check("tmo_pre_fail", {30'd0, fail_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) press_key(code_def[i], 1, 3);
    idle(40);
    check("tmo_fail_kept", {30'd0, fail_cnt}, 32'd1);
    check("tmo_err_once", 32'(err_count - err_base), 32'd1);
    enter_code(code_def);
    check("tmo_then_open", {31'd0, y}, 32'd1);
    check("tmo_open_fail", {30'd0, fail_cnt}, 32'd0);
    idle(25);

    // press landing on the expiry cycle keeps the entry alive
    press_key(code_def[0], 1, TMO_C - 1);
    for (int i = 1; i < 5; i++) press_key(code_def[i], 1, 3);
    check("tmo_edge_open", {31'd0, y}, 32'd1);
    idle(25);

    // lockout after three wrong codes
    err_base = err_count;
    enter_code(code_bad);
    check("lock_fail1", {30'd0, fail_cnt}, 32'd1);
    enter_code(code_bad);
    check("lock_fail2", {30'd0, fail_cnt}, 32'd2);
    enter_code(code_bad);
    check("lock_fail3", {30'd0, fail_cnt}, 32'd3);
    check("lock_alarm", {31'd0, alarm}, 32'd1);
    check("lock_err_pulses", 32'(err_count - err_base), 32'd3);
    enter_code(code_def);
    check("lock_ignores_code", {31'd0, y}, 32'd0);
    idle(40);
    check("lock_len", 32'(last_alarm_run), 32'd50);
    check("lock_alarm_off", {31'd0, alarm}, 32'd0);
    check("lock_fail_clr", {30'd0, fail_cnt}, 32'd0);
    enter_code(code_def);
    check("lock_then_open", {31'd0, y}, 32'd1);
    idle(25);

    // reprogram to 10,10,01,11,01
    enter_code(code_def);
    prog = 1'b1;
    enter_code(code_new);
    prog = 1'b0;
    check("prog_closed", {31'd0, y}, 32'd0);
    err_base = err_count;
    enter_code(code_def);
    check("prog_old_err", 32'(err_count - err_base), 32'd1);
    check("prog_old_closed", {31'd0, y}, 32'd0);
    enter_code(code_new);
    check("prog_new_open", {31'd0, y}, 32'd1);
    idle(25);

    // reset during PROG after 3 new symbols, key held across release
    enter_code(code_new);
    prog = 1'b1;
    for (int i = 0; i < 3; i++) press_key(code_bad[i], 1, 3);
    check("midprog_y", {31'd0, y}, 32'd1);
    #1 rst = 1'b0;
    #1 check("rst_async_y", {31'd0, y}, 32'd0);
    check("rst_async_fail", {30'd0, fail_cnt}, 32'd0);
    prog = 1'b0;
    @(negedge clk);
    x = 2'b01;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    x = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 1; i < 5; i++) press_key(code_def[i], 1, 3);
    check("rst_default_open", {31'd0, y}, 32'd1);
    idle(25);

    // random keypad traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      prog = ($urandom_range(0, 3) == 0);
      if (r < 2) begin
        cur = m_code;
        for (int i = 0; i < 5; i++) press_key(cur[i], int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      end else if (r == 2) begin
        idle(int'($urandom_range(TMO_C - 3, TMO_C + 3)));
      end else if (r == 3) begin
        idle(int'($urandom_range(10, 25)));
      end else begin
        press_key(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 4)));
      end
    end
    prog = 1'b0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
